// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
//   Reads ASCII bytes in order from the 1024-byte receive buffer and plays
//   each one as Morse code on a single keying output. Letters (either case)
//   and digits are keyed with standard unit timing. A space adds a word gap.
//   Any other byte is consumed without keying.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous, active-high reset
//   i_w_address  buffer write pointer (next free slot)
//   i_data       buffer read data. It is registered, so it is valid one edge
//                after o_r_address is sampled.
//   o_r_address  read pointer into the buffer (next unread slot)
//   o_key        Morse key output, registered (1 = tone/LED on)
//   o_busy       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module morse_keyer #(
  parameter int unsigned UNIT_CYCLES = 2700000,  // clock cycles per Morse unit, >= 2
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_w_address,
  input  logic [7:0]        i_data,
  output logic [ADDR_W-1:0] o_r_address,
  output logic              o_key,
  output logic              o_busy
);

  localparam int unsigned CYC_W = $clog2(UNIT_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LATCH,
    S_ON,
    S_SYM_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  // Returns {length[2:0], pattern[4:0]}. The pattern is right-aligned,
  // dot = 0 and dash = 1, and the first symbol is the most significant used
  // bit. A length of 0 means the byte has no Morse pattern.
  function automatic logic [7:0] morse_lookup(input logic [7:0] c);
    logic [7:0] u;
    // Fold lower case onto upper case.
    u = (c >= 8'h61 && c <= 8'h7A) ? (c & 8'hDF) : c;
    case (u)
      8'h41: morse_lookup = {3'd2, 5'b00001};  // A .-
      8'h42: morse_lookup = {3'd4, 5'b01000};  // B -...
      8'h43: morse_lookup = {3'd4, 5'b01010};  // C -.-.
      8'h44: morse_lookup = {3'd3, 5'b00100};  // D -..
      8'h45: morse_lookup = {3'd1, 5'b00000};  // E .
      8'h46: morse_lookup = {3'd4, 5'b00010};  // F ..-.
      8'h47: morse_lookup = {3'd3, 5'b00110};  // G --.
      8'h48: morse_lookup = {3'd4, 5'b00000};  // H ....
      8'h49: morse_lookup = {3'd2, 5'b00000};  // I ..
      8'h4A: morse_lookup = {3'd4, 5'b00111};  // J .---
      8'h4B: morse_lookup = {3'd3, 5'b00101};  // K -.-
      8'h4C: morse_lookup = {3'd4, 5'b00100};  // L .-..
      8'h4D: morse_lookup = {3'd2, 5'b00011};  // M --
      8'h4E: morse_lookup = {3'd2, 5'b00010};  // N -.
      8'h4F: morse_lookup = {3'd3, 5'b00111};  // O ---
      8'h50: morse_lookup = {3'd4, 5'b00110};  // P .--.
      8'h51: morse_lookup = {3'd4, 5'b01101};  // Q --.-
      8'h52: morse_lookup = {3'd3, 5'b00010};  // R .-.
      8'h53: morse_lookup = {3'd3, 5'b00000};  // S ...
      8'h54: morse_lookup = {3'd1, 5'b00001};  // T -
      8'h55: morse_lookup = {3'd3, 5'b00001};  // U ..-
      8'h56: morse_lookup = {3'd4, 5'b00001};  // V ...-
      8'h57: morse_lookup = {3'd3, 5'b00011};  // W .--
      8'h58: morse_lookup = {3'd4, 5'b01001};  // X -..-
      8'h59: morse_lookup = {3'd4, 5'b01011};  // Y -.--
      8'h5A: morse_lookup = {3'd4, 5'b01100};  // Z --..
      8'h30: morse_lookup = {3'd5, 5'b11111};  // 0 -----
      8'h31: morse_lookup = {3'd5, 5'b01111};  // 1 .----
      8'h32: morse_lookup = {3'd5, 5'b00111};  // 2 ..---
      8'h33: morse_lookup = {3'd5, 5'b00011};  // 3 ...--
      8'h34: morse_lookup = {3'd5, 5'b00001};  // 4 ....-
      8'h35: morse_lookup = {3'd5, 5'b00000};  // 5 .....
      8'h36: morse_lookup = {3'd5, 5'b10000};  // 6 -....
      8'h37: morse_lookup = {3'd5, 5'b11000};  // 7 --...
      8'h38: morse_lookup = {3'd5, 5'b11100};  // 8 ---..
      8'h39: morse_lookup = {3'd5, 5'b11110};  // 9 ----.
      default: morse_lookup = 8'h00;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              key_q, key_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;    // cycle within the current unit
  logic [1:0]        unit_q, unit_d;  // units completed in the current state
  logic [4:0]        sym_q, sym_d;    // left-aligned; bit 4 is the current symbol
  logic [2:0]        cnt_q, cnt_d;    // symbols still to key, including the current one

  logic [7:0] lookup;
  logic       unit_end;
  logic [1:0] last_unit;
  logic       state_end;

  assign lookup   = morse_lookup(i_data);
  assign unit_end = (cyc_q == CYC_LAST);

  // Index of the final unit of the current timed state.
  always_comb begin
    last_unit = 2'd0;
    case (state_q)
      S_ON:       last_unit = sym_q[4] ? 2'd2 : 2'd0;
      S_CHAR_GAP: last_unit = 2'd2;
      S_WORD_GAP: last_unit = 2'd3;
      default:    last_unit = 2'd0;
    endcase
  end

  assign state_end = unit_end && (unit_q == last_unit);

  // State register and datapath flops.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      r_addr_q <= '0;
      key_q    <= 1'b0;
      cyc_q    <= '0;
      unit_q   <= '0;
      sym_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      r_addr_q <= r_addr_d;
      key_q    <= key_d;
      cyc_q    <= cyc_d;
      unit_q   <= unit_d;
      sym_q    <= sym_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (r_addr_q != i_w_address) state_d = S_WAIT;
      S_WAIT:     state_d = S_LATCH;
      S_LATCH: begin
        if (lookup[7:5] != 3'd0)  state_d = S_ON;
        else if (i_data == 8'h20) state_d = S_WORD_GAP;
        else                      state_d = S_IDLE;
      end
      S_ON:       if (state_end) state_d = (cnt_q > 3'd1) ? S_SYM_GAP : S_CHAR_GAP;
      S_SYM_GAP:  if (state_end) state_d = S_ON;
      S_CHAR_GAP: if (state_end) state_d = S_IDLE;
      S_WORD_GAP: if (state_end) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath: read pointer, unit timer and symbol shifter.
  always_comb begin
    r_addr_d = r_addr_q;
    cyc_d    = cyc_q;
    unit_d   = unit_q;
    sym_d    = sym_q;
    cnt_d    = cnt_q;

    // The unit timer restarts on every state change.
    if (state_d != state_q) begin
      cyc_d  = '0;
      unit_d = '0;
    end else if (unit_end) begin
      cyc_d  = '0;
      unit_d = unit_q + 2'd1;
    end else begin
      cyc_d  = cyc_q + 1'b1;
    end

    if (state_q == S_LATCH) begin
      r_addr_d = r_addr_q + 1'b1;
      sym_d    = lookup[4:0] << (3'd5 - lookup[7:5]);
      cnt_d    = lookup[7:5];
    end else if (state_q == S_ON && state_end) begin
      sym_d    = sym_q << 1;
      cnt_d    = cnt_q - 3'd1;
    end
  end

  // Output logic: the key flop follows the state being entered, so it rises
  // on the edge into ON and falls on the edge out of ON.
  always_comb begin
    key_d = (state_d == S_ON);
  end

  assign o_key       = key_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_r_address = r_addr_q;

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
//   Drives morse_keyer from a model of the registered receive buffer and
//   compares o_key, o_busy and o_r_address on every cycle against a timeline
//   built from dot/dash strings and Morse unit timing rules.
// -----------------------------------------------------------------------------
module tb_morse_keyer;

  localparam int U  = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] w_ptr;
  logic [AW-1:0] r_addr;
  logic [7:0]    rdata;
  logic          key;
  logic          busy;

  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  // Registered-read buffer model.
  always @(posedge clk) rdata <= mem[r_addr];

  morse_keyer #(.UNIT_CYCLES(U), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_w_address (w_ptr),
    .i_data      (rdata),
    .o_r_address (r_addr),
    .o_key       (key),
    .o_busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Morse as dot/dash text; empty string for bytes that are not keyed.
  function automatic string morse_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";
      "D": return "-..";   "E": return ".";     "F": return "..-.";
      "G": return "--.";   "H": return "....";  "I": return "..";
      "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";
      "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
      "S": return "...";   "T": return "-";     "U": return "..-";
      "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---";
      "3": return "...--"; "4": return "....-"; "5": return ".....";
      "6": return "-...."; "7": return "--..."; "8": return "---..";
      "9": return "----.";
      default: return "";
    endcase
  endfunction

  // Expected per-cycle timeline.
  int            q_key[$];
  int            q_busy[$];
  logic [AW-1:0] q_addr[$];
  logic [7:0]    seq[$];

  task automatic push(input int n, input int k, input int b, input logic [AW-1:0] a);
    for (int i = 0; i < n; i++) begin
      q_key.push_back(k);
      q_busy.push_back(b);
      q_addr.push_back(a);
    end
  endtask

  // Writes seq into the buffer while the keyer is idle with an empty buffer,
  // then checks every following cycle against the expected timeline.
  task automatic run_seq(input string name);
    logic [AW-1:0] a;
    string         s;
    int            n;
    a = w_ptr;
    q_key.delete();
    q_busy.delete();
    q_addr.delete();
    foreach (seq[j]) begin
      push(1, 0, 0, a);          // idle check
      push(2, 0, 1, a);          // buffer read latency, then capture
      a = a + 1'b1;
      s = morse_of(seq[j]);
      for (int i = 0; i < s.len(); i++) begin
        push((s[i] == 8'h2D) ? 3 * U : U, 1, 1, a);
        push((i == s.len() - 1) ? 3 * U : U, 0, 1, a);
      end
      if (s.len() == 0 && seq[j] == 8'h20) push(4 * U, 0, 1, a);
    end
    push(3, 0, 0, a);
    // The first idle cycle is the one in which the bytes are written.
    void'(q_key.pop_front());
    void'(q_busy.pop_front());
    void'(q_addr.pop_front());

    @(negedge clk);
    foreach (seq[j]) begin
      mem[w_ptr] = seq[j];
      w_ptr = w_ptr + 1'b1;
    end
    n = q_key.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s key c%0d", name, i), key, q_key[i]);
      check($sformatf("%s busy c%0d", name, i), busy, q_busy[i]);
      check($sformatf("%s addr c%0d", name, i), r_addr, q_addr[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    w_ptr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int r;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst   = 1'b1;
    w_ptr = '0;
    #1;
    check("reset key", key, 0);
    check("reset busy", busy, 0);
    check("reset addr", r_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("empty idle busy", busy, 0);
    check("empty idle addr", r_addr, 0);

    seq = '{8'h45};                 run_seq("E");
    seq = '{8'h61};                 run_seq("a");
    seq = '{8'h54, 8'h20, 8'h54};   run_seq("T_T");
    seq = '{8'h23, 8'h45};          run_seq("#E");
    seq = '{8'h30, 8'h31, 8'h39};   run_seq("digits");

    for (int it = 0; it < 8; it++) begin
      seq.delete();
      cnt = $urandom_range(1, 4);
      for (int j = 0; j < cnt; j++) begin
        r = $urandom_range(0, 4);
        case (r)
          0: seq.push_back(8'h41 + 8'($urandom_range(0, 25)));
          1: seq.push_back(8'h61 + 8'($urandom_range(0, 25)));
          2: seq.push_back(8'h30 + 8'($urandom_range(0, 9)));
          3: seq.push_back(8'h20);
          default: seq.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      run_seq($sformatf("rand%0d", it));
    end

    // Pointer wrap: fill with silent bytes and let the keyer run up to 1023.
    do_reset();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h23;
    @(negedge clk);
    w_ptr = 10'd1023;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!(r_addr == 10'd1023 && !busy) && cnt < 4000);
    check("wrap reach 1023", (r_addr == 10'd1023 && !busy) ? 1 : 0, 1);
    seq = '{8'h45, 8'h54};          run_seq("wrap");
    check("wrap final addr", r_addr, 1);

    // Asynchronous reset in the middle of a dash.
    @(negedge clk);
    mem[w_ptr] = 8'h54;
    w_ptr = w_ptr + 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid dash key", key, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst key", key, 0);
    check("async rst busy", busy, 0);
    check("async rst addr", r_addr, 0);
    w_ptr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post rst key c%0d", i), key, 0);
      check($sformatf("post rst busy c%0d", i), busy, 0);
      check($sformatf("post rst addr c%0d", i), r_addr, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Consumer stage directly downstream of the 1024-byte receive buffer.
- Reads ASCII bytes from the buffer in order, tracking its own read pointer against the buffer's write pointer.
- Looks up the Morse pattern for each byte and drives a single keying output with standard unit timing (dot, dash and gaps).
- o_key feeds the LED/buzzer driver at top level.

Parameters:
- UNIT_CYCLES, 2700000, clock cycles per Morse time unit (100 ms at 27 MHz); must be >= 2.
- ADDR_W, 10, buffer address width; must match the buffer depth of 1024.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- i_w_address  input  ADDR_W  buffer write pointer (next free slot)
- i_data  input  8  buffer read data; registered, so it is valid one edge after o_r_address is sampled
- o_r_address  output  ADDR_W  read pointer to the buffer (next unread slot)
- o_key  output  1  Morse key: 1 = tone/LED on
- o_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, o_r_address=0, o_key=0, o_busy=0.
  - Unit counter, symbol shift register and symbol count all cleared.
  - Takes effect immediately, including mid-symbol: o_key drops without waiting for a clock edge.
- Empty condition: o_r_address == i_w_address. No other full/overrun detection; the pointer wraps modulo 2^ADDR_W (1023 -> 0).
- States:
  - IDLE: if not empty, go to WAIT. o_r_address is already stable.
  - WAIT: one cycle, during which the buffer presents memory[o_r_address] on i_data.
  - LATCH: capture i_data; o_r_address += 1; decode the byte.
    - Letter (A-Z / a-z, case-insensitive) or digit 0-9: load pattern (length 1-5, dot=0/dash=1, first symbol first), go to ON.
    - 0x20 (space): go to WORD_GAP.
    - Any other byte: consumed silently, back to IDLE, o_key stays 0.
  - ON: o_key=1 for 1 unit (dot) or 3 units (dash). On expiry, if symbols remain go to SYM_GAP, else go to CHAR_GAP.
  - SYM_GAP: o_key=0 for 1 unit, then ON with the next symbol.
  - CHAR_GAP: o_key=0 for 3 units, then IDLE.
  - WORD_GAP: o_key=0 for 4 units, then IDLE. Combined with the preceding CHAR_GAP this gives the standard 7-unit word gap.
- Unit counter:
  - Counts 0..UNIT_CYCLES-1 and reloads on each state entry.
  - "N units" means exactly N*UNIT_CYCLES clock cycles in that state.
- o_key is registered:
  - Rises on the edge that enters ON.
  - Falls on the edge that leaves ON.
- Timing between bytes:
  - Byte-to-first-key latency from IDLE with data present: 3 edges (IDLE->WAIT->LATCH->ON).
  - IDLE always spends at least one cycle between bytes.
- The buffer may write concurrently at any time. Only i_w_address is compared, so a byte written in the same cycle is picked up on the next IDLE check.
- Digits use the 5-symbol ITU patterns (e.g. '1' = .----, '0' = -----).

Test Plan:
- UNIT_CYCLES=4; write 'E' (0x45), i_w_address 0->1 -> after 3 edges o_key=1 for exactly 4 cycles, then 0 for 12 cycles; o_r_address=1; o_busy falls afterwards.
- Write 'a' (0x61) -> o_key high 4, low 4, high 12, low 12 (identical to 'A').
- Write "T T" (0x54,0x20,0x54) -> high 12, low 12, low 16 (word gap), then high 12 for the second T; o_r_address=3.
- Write '#' (0x23) then 'E' -> no key activity for '#', o_r_address steps 0->1->2, only one 4-cycle pulse observed.
- Preload o_r_address/i_w_address at 1023, write 'E' at 1023 and 'T' at 0 -> both keyed in order, o_r_address wraps to 0 then 1.
- Assert i_rst mid-dash of 'T' -> o_key=0 asynchronously, o_r_address=0, state IDLE; after release with i_w_address=0 the block stays idle.
